// File: rtl/north_axi_slave_mem_if.sv
// AXI4 bundle (no IDs) between the 512-bit north-role master and its memory responder.
// The master modport drives requests and write data; the slave modport drives responses.
interface north_axi_slave_mem_if;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic [3:0]   awcache;
  logic [3:0]   awqos;
  logic [3:0]   awregion;
  logic [2:0]   awprot;
  logic         awlock;
  logic         awvalid;
  logic         awready;

  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;

  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [3:0]   arcache;
  logic [3:0]   arqos;
  logic [3:0]   arregion;
  logic [2:0]   arprot;
  logic         arlock;
  logic         arvalid;
  logic         arready;

  logic [511:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awcache, awqos, awregion, awprot, awlock, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arcache, arqos, arregion, arprot, arlock, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awcache, awqos, awregion, awprot, awlock, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arcache, arqos, arregion, arprot, arlock, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/north_axi_slave_mem.sv
// Single-outstanding AXI4 memory responder for the 512-bit north-role master port.
// Define NORTH_SLV_WSTRB_EN to honour wstrb byte enables; otherwise beats write whole words.
module north_axi_slave_mem #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [63:0] BASE_ADDR  = 64'h0
) (
  input logic                  CLK_IN_250,
  input logic                  AXI_RESET_N,
  north_axi_slave_mem_if.slave S_AXI_NORTH_TO_STATIC
);

  localparam int unsigned NumWords = 1 << DEPTH_LOG2;
  // One spare bit above the 58-bit word offset so INCR bursts never wrap back into the window.
  localparam int unsigned IdxW = 59;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [1:0] {StIdle, StWrData, StWrResp, StRdData} state_e;

  state_e            state_q, state_d;
  logic              armed_q;
  logic              arb_wr_first_q, arb_wr_first_d;
  logic              aw_acc, ar_acc;
  logic [IdxW-1:0]   idx_q;
  logic [7:0]        len_q, beat_q;
  logic              incr_q, type_err_q;
  logic [1:0]        resp_q;
  logic              rvalid_q, rlast_q;
  logic [1:0]        rresp_q;
  logic [511:0]      rdata_q;
  logic [511:0]      mem [NumWords];

  logic              in_range, beat_ok, last_beat, wlast_err;
  logic              w_hs, r_load, r_done;
  logic [1:0]        beat_resp, w_resp;

  function automatic logic [IdxW-1:0] word_index(input logic [63:0] addr);
    return IdxW'((addr - BASE_ADDR) >> 6);
  endfunction

  function automatic logic type_bad(input logic [1:0] burst, input logic [2:0] size);
    return !(burst == 2'b00 || burst == 2'b01) || (size != 3'b110);
  endfunction

  // Response codes are ordered numerically by severity: OKAY < SLVERR < DECERR.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    in_range  = (idx_q >> DEPTH_LOG2) == '0;
    beat_ok   = in_range && !type_err_q;
    last_beat = beat_q == len_q;
    wlast_err = S_AXI_NORTH_TO_STATIC.wlast != last_beat;
    beat_resp = !in_range ? RespDecErr : (type_err_q ? RespSlvErr : RespOkay);
    w_resp    = worst(worst(resp_q, beat_resp), wlast_err ? RespSlvErr : RespOkay);
    w_hs      = (state_q == StWrData) && S_AXI_NORTH_TO_STATIC.wvalid;
    r_load    = (state_q == StRdData) && (!rvalid_q || (S_AXI_NORTH_TO_STATIC.rready && !rlast_q));
    r_done    = (state_q == StRdData) && rvalid_q && S_AXI_NORTH_TO_STATIC.rready && rlast_q;
  end

  always_comb begin
    state_d        = state_q;
    arb_wr_first_d = arb_wr_first_q;
    aw_acc         = 1'b0;
    ar_acc         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (armed_q) begin
          if (S_AXI_NORTH_TO_STATIC.awvalid &&
              (!S_AXI_NORTH_TO_STATIC.arvalid || arb_wr_first_q)) begin
            aw_acc = 1'b1;
          end else if (S_AXI_NORTH_TO_STATIC.arvalid) begin
            ar_acc = 1'b1;
          end
          // Pointer only flips on contention, so a lone request never steals the other's turn.
          if (S_AXI_NORTH_TO_STATIC.awvalid && S_AXI_NORTH_TO_STATIC.arvalid) begin
            arb_wr_first_d = !arb_wr_first_q;
          end
          if (aw_acc) begin
            state_d = StWrData;
          end else if (ar_acc) begin
            state_d = StRdData;
          end
        end
      end
      StWrData: if (w_hs && last_beat) state_d = StWrResp;
      StWrResp: if (S_AXI_NORTH_TO_STATIC.bready) state_d = StIdle;
      StRdData: if (r_done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign S_AXI_NORTH_TO_STATIC.awready = aw_acc;
  assign S_AXI_NORTH_TO_STATIC.arready = ar_acc;
  assign S_AXI_NORTH_TO_STATIC.wready  = state_q == StWrData;
  assign S_AXI_NORTH_TO_STATIC.bvalid  = state_q == StWrResp;
  assign S_AXI_NORTH_TO_STATIC.bresp   = resp_q;
  assign S_AXI_NORTH_TO_STATIC.rvalid  = rvalid_q;
  assign S_AXI_NORTH_TO_STATIC.rdata   = rdata_q;
  assign S_AXI_NORTH_TO_STATIC.rresp   = rresp_q;
  assign S_AXI_NORTH_TO_STATIC.rlast   = rlast_q;

  always_ff @(posedge CLK_IN_250 or negedge AXI_RESET_N) begin
    if (!AXI_RESET_N) begin
      state_q        <= StIdle;
      armed_q        <= 1'b0;
      arb_wr_first_q <= 1'b1;
      idx_q          <= '0;
      len_q          <= '0;
      beat_q         <= '0;
      incr_q         <= 1'b0;
      type_err_q     <= 1'b0;
      resp_q         <= RespOkay;
      rvalid_q       <= 1'b0;
      rlast_q        <= 1'b0;
      rresp_q        <= RespOkay;
      rdata_q        <= '0;
    end else begin
      state_q        <= state_d;
      armed_q        <= 1'b1;
      arb_wr_first_q <= arb_wr_first_d;
      if (aw_acc) begin
        idx_q      <= word_index(S_AXI_NORTH_TO_STATIC.awaddr);
        len_q      <= S_AXI_NORTH_TO_STATIC.awlen;
        incr_q     <= S_AXI_NORTH_TO_STATIC.awburst == 2'b01;
        type_err_q <= type_bad(S_AXI_NORTH_TO_STATIC.awburst, S_AXI_NORTH_TO_STATIC.awsize);
        beat_q     <= '0;
        resp_q     <= RespOkay;
      end else if (ar_acc) begin
        idx_q      <= word_index(S_AXI_NORTH_TO_STATIC.araddr);
        len_q      <= S_AXI_NORTH_TO_STATIC.arlen;
        incr_q     <= S_AXI_NORTH_TO_STATIC.arburst == 2'b01;
        type_err_q <= type_bad(S_AXI_NORTH_TO_STATIC.arburst, S_AXI_NORTH_TO_STATIC.arsize);
        beat_q     <= '0;
      end
      if (w_hs) begin
        resp_q <= w_resp;
        beat_q <= beat_q + 8'd1;
        if (incr_q) idx_q <= idx_q + IdxW'(1);
      end
      // Read output register doubles as the synchronous RAM read port.
      if (r_load) begin
        rvalid_q <= 1'b1;
        rdata_q  <= beat_ok ? mem[idx_q[DEPTH_LOG2-1:0]] : '0;
        rresp_q  <= beat_resp;
        rlast_q  <= last_beat;
        beat_q   <= beat_q + 8'd1;
        if (incr_q) idx_q <= idx_q + IdxW'(1);
      end else if (r_done) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_IN_250) begin
    if (w_hs && beat_ok) begin
`ifdef NORTH_SLV_WSTRB_EN
      for (int b = 0; b < 64; b++) begin
        if (S_AXI_NORTH_TO_STATIC.wstrb[b]) begin
          mem[idx_q[DEPTH_LOG2-1:0]][8*b +: 8] <= S_AXI_NORTH_TO_STATIC.wdata[8*b +: 8];
        end
      end
`else
      mem[idx_q[DEPTH_LOG2-1:0]] <= S_AXI_NORTH_TO_STATIC.wdata;
`endif
    end
  end

  logic unused_sideband;
  assign unused_sideband = ^{S_AXI_NORTH_TO_STATIC.awcache, S_AXI_NORTH_TO_STATIC.awqos,
                             S_AXI_NORTH_TO_STATIC.awregion, S_AXI_NORTH_TO_STATIC.awprot,
                             S_AXI_NORTH_TO_STATIC.awlock, S_AXI_NORTH_TO_STATIC.arcache,
                             S_AXI_NORTH_TO_STATIC.arqos, S_AXI_NORTH_TO_STATIC.arregion,
                             S_AXI_NORTH_TO_STATIC.arprot, S_AXI_NORTH_TO_STATIC.arlock
`ifndef NORTH_SLV_WSTRB_EN
                             , S_AXI_NORTH_TO_STATIC.wstrb
`endif
                             };

endmodule

// File: tb/tb_north_axi_slave_mem.sv
// Scoreboard bench for north_axi_slave_mem: a reference memory model predicts every B and R beat.
module tb_north_axi_slave_mem;
  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned WORDS      = 1 << DEPTH_LOG2;
  localparam logic [63:0] BASE       = 64'h0000_0000_0001_0000;
  localparam logic [1:0]  OKAY = 2'b00, SLV = 2'b10, DEC = 2'b11;

  typedef struct packed {
    logic [511:0] d;
    logic [1:0]   r;
    logic         l;
  } rexp_t;

  logic clk, rst_n;
  north_axi_slave_mem_if bus ();

  north_axi_slave_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .BASE_ADDR  (BASE)
  ) dut (
    .CLK_IN_250             (clk),
    .AXI_RESET_N            (rst_n),
    .S_AXI_NORTH_TO_STATIC  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int acc_seq = 0;
  int aw_seq  = 0;
  int ar_seq  = 0;
  logic [1:0]   bq [$];
  rexp_t        rq [$];
  logic [511:0] model_mem [WORDS];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [511:0] pat(input int seed, input int beat);
    logic [511:0] v;
    if (seed == 0) return '0;
    if (seed == -1) return '1;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = 32'(seed * 1000003 + beat * 7919 + k * 104729);
    return v;
  endfunction

  task automatic model_wr(input int idx, input logic [511:0] data, input logic [63:0] strb);
`ifdef NORTH_SLV_WSTRB_EN
    for (int b = 0; b < 64; b++) if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
`else
    model_mem[idx] = data;
`endif
  endtask

  function automatic logic [63:0] beat_idx(input logic [63:0] addr, input logic [1:0] burst,
                                           input int i);
    return ((addr - BASE) >> 6) + ((burst == 2'b01) ? 64'(i) : 64'd0);
  endfunction

  task automatic push_read(input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
    rexp_t e;
    logic [63:0] idx;
    for (int i = 0; i <= int'(len); i++) begin
      idx = beat_idx(addr, burst, i);
      e.l = (i == int'(len));
      if (idx >= 64'(WORDS)) begin
        e.d = '0; e.r = DEC;
      end else if (burst > 2'b01 || size != 3'b110) begin
        e.d = '0; e.r = SLV;
      end else begin
        e.d = model_mem[int'(idx)]; e.r = OKAY;
      end
      rq.push_back(e);
    end
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [63:0] strb, input int seed,
                          input int flip);
    logic [1:0]  resp;
    logic [63:0] idx;
    int cyc;
    resp = OKAY;
    for (int i = 0; i <= int'(len); i++) begin
      idx = beat_idx(addr, burst, i);
      if (idx >= 64'(WORDS)) resp = worst(resp, DEC);
      else if (burst > 2'b01 || size != 3'b110) resp = worst(resp, SLV);
      else model_wr(int'(idx), pat(seed, i), strb);
      if (i == flip) resp = worst(resp, SLV);
    end
    bq.push_back(resp);
    @(posedge clk); #1;
    bus.awaddr = addr; bus.awlen = len; bus.awburst = burst; bus.awsize = size;
    bus.awvalid = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.awready && cyc < 600);
    if (!bus.awready) begin
      check("aw_timeout", 0, 1);
      bus.awvalid = 1'b0;
      void'(bq.pop_back());
      return;
    end
    @(posedge clk); acc_seq++; aw_seq = acc_seq; #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata = pat(seed, i); bus.wstrb = strb;
      bus.wlast = (i == int'(len)) != (i == flip);
      bus.wvalid = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!bus.wready && cyc < 20);
      if (!bus.wready) begin
        check("w_timeout", 0, 1);
        bus.wvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(bus.bvalid && bus.bready) && cyc < 20);
    if (!bus.bvalid) check("b_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [7:0] rpat, output int lat);
    int cyc, k;
    bit done;
    lat = 0;
    push_read(addr, len, burst, size);
    @(posedge clk); #1;
    bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arsize = size;
    bus.arvalid = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.arready && cyc < 600);
    if (!bus.arready) begin
      check("ar_timeout", 0, 1);
      bus.arvalid = 1'b0;
      rq.delete();
      return;
    end
    @(posedge clk); acc_seq++; ar_seq = acc_seq; #1;
    bus.arvalid = 1'b0;
    k = 0; done = 0; cyc = 0;
    bus.rready = rpat[0];
    while (!done && cyc < 2000) begin
      @(negedge clk); cyc++;
      if (bus.rvalid && lat == 0) lat = cyc;
      if (bus.rvalid && bus.rready && bus.rlast) done = 1;
      @(posedge clk); #1;
      k++;
      bus.rready = rpat[k % 8];
    end
    bus.rready = 1'b0;
    if (!done) check("r_timeout", 0, 1);
  endtask

  // Compare every presented beat against the queue head; pop only on the handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.bvalid) begin
        if (bq.size() == 0) check("b_unexpected", 1, 0);
        else begin
          check("bresp", bus.bresp, bq[0]);
          if (bus.bready) void'(bq.pop_front());
        end
      end
      if (bus.rvalid) begin
        if (rq.size() == 0) check("r_unexpected", 1, 0);
        else begin
          check("rdata", bus.rdata, rq[0].d);
          check("rresp", bus.rresp, rq[0].r);
          check("rlast", bus.rlast, rq[0].l);
          if (bus.rready) void'(rq.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cyc;
    bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'b110; bus.awburst = 2'b01;
    bus.awcache = 4'hF; bus.awqos = 4'h5; bus.awregion = 4'hA; bus.awprot = 3'h7;
    bus.awlock = 1'b1;
    bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'b110; bus.arburst = 2'b01;
    bus.arcache = 4'h3; bus.arqos = 4'hC; bus.arregion = 4'h6; bus.arprot = 3'h2;
    bus.arlock = 1'b1;
    bus.wdata = '0; bus.wstrb = '1; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.rready = 1'b0;
    for (int i = 0; i < int'(WORDS); i++) model_mem[i] = '0;

    // Requests held during reset must not be accepted.
    rst_n = 1'b0; bus.awvalid = 1'b1; bus.arvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", bus.awready, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_bresp", bus.bresp, 0);
    check("rst_rresp", bus.rresp, 0);
    check("rst_rlast", bus.rlast, 0);
    check("rst_rdata", bus.rdata, 0);
    bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    do_write(BASE, 8'd15, 2'b01, 3'b110, '1, 1, -1);
    do_write(BASE + 64'h40, 8'd3, 2'b01, 3'b110, '1, 2, -1);
    do_read(BASE + 64'h40, 8'd3, 2'b01, 3'b110, 8'hFF, lat);
    check("rd_first_latency", lat, 2);

    fork
      do_write(BASE + 64'h100, 8'd1, 2'b01, 3'b110, '1, 3, -1);
      do_read(BASE + 64'h200, 8'd1, 2'b01, 3'b110, 8'hFF, lat);
    join
    check("arb_write_first", aw_seq < ar_seq, 1);
    fork
      do_write(BASE + 64'h280, 8'd1, 2'b01, 3'b110, '1, 4, -1);
      do_read(BASE + 64'h300, 8'd1, 2'b01, 3'b110, 8'hFF, lat);
    join
    check("arb_read_first", ar_seq < aw_seq, 1);

    do_read(BASE + 64'h40, 8'd3, 2'b01, 3'b110, 8'b1001_1001, lat);

    do_write(BASE + 64'(64 * WORDS) - 64'd64, 8'd1, 2'b01, 3'b110, '1, 5, -1);
    do_read(BASE + 64'(64 * WORDS) - 64'd64, 8'd1, 2'b01, 3'b110, 8'hFF, lat);

    do_write(BASE + 64'h80, 8'd0, 2'b01, 3'b110, '1, -1, -1);
    do_write(BASE + 64'h80, 8'd0, 2'b01, 3'b110, 64'h0000_0000_0000_00FF, 0, -1);
    do_read(BASE + 64'h80, 8'd0, 2'b01, 3'b110, 8'hFF, lat);

    do_write(BASE + 64'h140, 8'd255, 2'b00, 3'b110, '1, 6, -1);
    do_read(BASE + 64'h140, 8'd0, 2'b01, 3'b110, 8'hFF, lat);
    do_write(BASE + 64'h180, 8'd3, 2'b10, 3'b110, '1, 7, -1);
    do_write(BASE + 64'h1C0, 8'd0, 2'b01, 3'b101, '1, 8, -1);
    do_read(BASE + 64'h180, 8'd1, 2'b01, 3'b110, 8'hFF, lat);
    do_write(BASE + 64'h240, 8'd3, 2'b01, 3'b110, '1, 9, 1);
    do_write(BASE + 64'h2C0, 8'd2, 2'b01, 3'b110, '1, 10, 2);
    do_read(BASE + 64'h240, 8'd4, 2'b01, 3'b110, 8'hFF, lat);
    do_write(BASE - 64'd64, 8'd1, 2'b01, 3'b110, '1, 11, -1);
    do_read(BASE, 8'd255, 2'b01, 3'b110, 8'hFF, lat);

    // Reset while beat 2 of a 4-beat read is on the bus.
    push_read(BASE + 64'h40, 8'd3, 2'b01, 3'b110);
    @(posedge clk); #1;
    bus.araddr = BASE + 64'h40; bus.arlen = 8'd3; bus.arburst = 2'b01; bus.arsize = 3'b110;
    bus.arvalid = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.arready && cyc < 20);
    check("rst_mid_ar", bus.arready, 1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.rvalid && cyc < 20);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_rvalid", bus.rvalid, 0);
    check("rst_mid_rlast", bus.rlast, 0);
    check("rst_mid_rdata", bus.rdata, 0);
    check("rst_mid_beats_left", rq.size(), 3);
    rq.delete();
    bus.rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_rvalid", bus.rvalid, 0);
    check("post_rst_bvalid", bus.bvalid, 0);
    do_read(BASE + 64'h40, 8'd0, 2'b01, 3'b110, 8'hFF, lat);

    repeat (4) @(posedge clk);
    check("bq_drained", bq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/north_axi_slave_mem.md
NORTH_AXI_SLAVE_MEM -- requirements
Module: north_axi_slave_mem

Interface
REQ-001 Parameter DEPTH_LOG2, default 8: memory holds 2^DEPTH_LOG2 words of 512 bits.
REQ-002 Parameter BASE_ADDR, default 64'h0: byte base address of the memory window, aligned to window size.
REQ-003 CLK_IN_250  in  1  single clock for all logic.
REQ-004 AXI_RESET_N  in  1  asynchronous, active-low reset.
REQ-005 AW channel: S_AXI_NORTH_TO_STATIC_awaddr in 64, awlen in 8, awsize in 3, awburst in 2, awvalid in 1, awready out 1.
REQ-006 AW sideband: awcache, awqos, awregion in 4 each; awprot in 3; awlock in 1; all accepted and ignored.
REQ-007 W channel: wdata in 512, wstrb in 64, wlast in 1, wvalid in 1, wready out 1.
REQ-008 B channel: bresp out 2, bvalid out 1, bready in 1.
REQ-009 AR channel: araddr, arlen, arsize, arburst, arvalid in, plus sideband with the same widths as AW and ignored; arready out 1.
REQ-010 R channel: rdata out 512, rresp out 2, rlast out 1, rvalid out 1, rready in 1.

Function
REQ-011 Block is the AXI4 responder for the 512-bit north-role master port; no ID signals; one transaction in flight at a time.
REQ-012 FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA.
REQ-013 IDLE: if only awvalid, go to WR_DATA; if only arvalid, go to RD_DATA; if both, alternate, with write first after reset.
REQ-014 awready/arready asserted only in IDLE, for the single accept cycle; the address, len, and burst are latched on that cycle.
REQ-015 Word index = (addr - BASE_ADDR) >> 6; addr[5:0] ignored.
REQ-016 INCR: index +1 per beat; FIXED: index constant; WRAP and reserved burst types: data beats still completed, no memory writes, response SLVERR (2'b10).
REQ-017 awsize/arsize other than 3'b110: same handling as REQ-016 (SLVERR).
REQ-018 Any beat whose address falls outside [BASE_ADDR, BASE_ADDR + 64*2^DEPTH_LOG2): write discarded, read data zero, response DECERR (2'b11); beats inside the window remain OKAY unless REQ-016/017 applies.
REQ-019 WR_DATA: wready = 1; each w handshake writes one beat. Exit to WR_RESP on the beat with count == awlen; wlast is not used for counting.
REQ-020 wlast mismatch (asserted early or missing on final beat): response SLVERR; beat count still governs.
REQ-021 WR_RESP: bvalid = 1 with the worst accumulated response (DECERR > SLVERR > OKAY); bvalid held until bready; return to IDLE on the b handshake.
REQ-022 RD_DATA: synchronous memory read; first rvalid two cycles after the ar handshake; later beats one cycle after each r handshake, or back-to-back with a prefetch stage.
REQ-023 rdata, rresp, and rlast held stable while rvalid && !rready; rlast = 1 on beat awlen/arlen + 1 only.
REQ-024 Return to IDLE on the final r handshake; the next accept occurs no earlier than the following cycle.
REQ-025 Burst length 256 (len = 255) fully supported; the beat counter is 8-bit with no wrap before completion.
REQ-026 INCR index wrap past the window end: the beats become out-of-range per REQ-018; no aliasing.

Reset
REQ-027 AXI_RESET_N low asynchronously forces: state IDLE; awready, arready, wready, bvalid, and rvalid = 0; bresp and rresp = 2'b00; rlast = 0; rdata = 0; arbitration pointer = write.
REQ-028 Memory contents are not cleared by reset.
REQ-029 Reset mid-burst abandons the transaction; no response is issued after reset deasserts.

Configuration
REQ-030 Macro NORTH_SLV_WSTRB_EN defined: each write beat updates only the bytes whose wstrb bit is 1.
REQ-031 Macro NORTH_SLV_WSTRB_EN undefined: wstrb is ignored and every accepted in-range beat writes all 64 bytes.

Verification
REQ-032 Write INCR awaddr=BASE+0x40, awlen=3, data D0..D3, wlast on beat 4 -> bresp OKAY; read the same burst -> rdata D0..D3, rlast on beat 4 only, rresp OKAY, first rvalid 2 cycles after arready.
REQ-033 Simultaneous awvalid and arvalid after reset -> write accepted first, read accepted after bvalid/bready; repeat the simultaneous request -> read first.
REQ-034 rready toggled 1-0-0-1 during a 4-beat read -> rdata, rlast, and rresp stable while stalled; no beats lost or duplicated.
REQ-035 Write at BASE + 64*2^DEPTH_LOG2 - 64, awlen=1 -> bresp DECERR; a read-back of the first word shows the new data and the second word returns 0 with DECERR.
REQ-036 With NORTH_SLV_WSTRB_EN: write all-ones, then write zeros with wstrb = 64'h0000_0000_0000_00FF -> read shows low 8 bytes zero and the rest ones. Without the macro, the same sequence -> the whole word reads zero.
REQ-037 Assert AXI_RESET_N low during beat 2 of a 4-beat read -> rvalid 0 immediately; after release, a new 1-beat read completes OKAY.
